spi_sclk_engine: RTL

Parametrised SPI serial-clock and frame-timing engine: it generates SCLK for one frame of 1 to 2^LEN_W bits with programmable polarity, phase, prescaler and frame length. It also produces registered per-bit sample and shift strobes plus a start/busy/done handshake. It sits between the APB register block and the SPI shift register, and replaces the free-running divider so that the shifter never derives edges itself.

---
 rtl/spi_sclk_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_sclk_engine.sv
// rtl/spi_sclk_engine.sv - SPI SCLK and frame-timing engine; optional abort via SPI_SCLK_ABORT_EN
module spi_sclk_engine #(
    parameter int SPPR_W = 3,
    parameter int SPR_W  = 3,
    parameter int DIV_W  = 12,
    parameter int LEN_W  = 5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              start,
    input  logic              abort,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SPPR_W-1:0] sppr,
    input  logic [SPR_W-1:0]  spr,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              sclk,
    output logic              sample_strobe,
    output logic              shift_strobe,
    output logic [LEN_W-1:0]  bit_idx,
    output logic              busy,
    output logic              done
);

    localparam int E_W = LEN_W + 2;

    typedef enum logic [1:0] {IDLE, LEAD, RUN, TRAIL} state_t;
    state_t state;

    logic             cpol_q;
    logic             cpha_q;
    logic [LEN_W-1:0] len_q;
    logic [DIV_W-1:0] hm1_q;
    logic [DIV_W-1:0] cnt;
    logic [E_W-1:0]   ecnt;

    logic [DIV_W-1:0] h_new;
    logic [E_W-1:0]   edge_k;
    logic [E_W-1:0]   two_n;
    logic             tick;
    logic             abort_req;

`ifdef SPI_SCLK_ABORT_EN
    assign abort_req = abort;
`else
    logic abort_unused;
    assign abort_unused = abort;
    assign abort_req    = 1'b0;
`endif

    // Half period widened before the shift so sppr=max, spr=max cannot truncate
    always_comb begin
        h_new  = (DIV_W'(sppr) + DIV_W'(1)) << spr;
        tick   = (cnt == '0);
        edge_k = ecnt + E_W'(1);
        two_n  = (E_W'(len_q) + E_W'(1)) << 1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= IDLE;
            sclk          <= 1'b0;
            sample_strobe <= 1'b0;
            shift_strobe  <= 1'b0;
            bit_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            len_q         <= '0;
            hm1_q         <= '0;
            cnt           <= '0;
            ecnt          <= '0;
        end else begin
            sample_strobe <= 1'b0;
            shift_strobe  <= 1'b0;
            done          <= 1'b0;
            if (sample_strobe && bit_idx != len_q)
                bit_idx <= bit_idx + LEN_W'(1);

            case (state)
                IDLE: begin
                    sclk    <= cpol;
                    bit_idx <= '0;
                    // The done cycle is IDLE too; a start there must be re-issued
                    if (start && !done) begin
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        len_q  <= frame_len;
                        hm1_q  <= h_new - DIV_W'(1);
                        cnt    <= h_new - DIV_W'(1);
                        ecnt   <= '0;
                        busy   <= 1'b1;
                        state  <= LEAD;
                    end
                end
                default: begin
                    if (tick && state == TRAIL) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sclk    <= cpol_q;
                        bit_idx <= '0;
                    end else if (abort_req) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        sclk    <= cpol_q;
                        bit_idx <= '0;
                    end else if (tick) begin
                        cnt  <= hm1_q;
                        ecnt <= edge_k;
                        sclk <= ~sclk;
                        // Odd edges lead away from cpol, even edges return to it
                        if (edge_k[0]) begin
                            sample_strobe <= ~cpha_q;
                            shift_strobe  <= cpha_q;
                        end else begin
                            sample_strobe <= cpha_q;
                            shift_strobe  <= ~cpha_q && (edge_k != two_n);
                        end
                        state <= (edge_k == two_n) ? TRAIL : RUN;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
